// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl
//   Fetch/dispatch sequencer in front of program_counter. Fetches the
//   instruction at pc over a req/ack port. JMP and HALT are resolved locally.
//   Everything else goes to the execute unit, and the result then becomes a
//   single load_pc or incr_pc pulse.
//
//   Optional feature: define FETCH_TIMEOUT_EN to build a fetch watchdog. If
//   mem_ack is withheld for TIMEOUT cycles, the controller parks in FAULT.
//
// Ports
//   clk, reset_n          clock, synchronous active-low reset
//   run                   start/continue; sampled only in IDLE and UPDATE
//   pc                    current PC from program_counter
//   load_pc/incr_pc/pc_in PC update pulses and load value
//   mem_req/mem_addr      fetch request (level) and address
//   mem_rdata/mem_ack     fetched word and completion strobe
//   instr/instr_valid     instruction handed to the execute unit
//   exec_done             execute unit finished instr
//   branch_taken/target   qualify exec_done with a PC load
//   halted, fault         sticky terminal status
module pc_fetch_ctrl #(
    parameter int size    = 16,
    parameter int IW      = 16,
    parameter int TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            run,
    input  logic [size-1:0] pc,
    output logic            load_pc,
    output logic            incr_pc,
    output logic [size-1:0] pc_in,
    output logic            mem_req,
    output logic [size-1:0] mem_addr,
    input  logic [IW-1:0]   mem_rdata,
    input  logic            mem_ack,
    output logic [IW-1:0]   instr,
    output logic            instr_valid,
    input  logic            exec_done,
    input  logic            branch_taken,
    input  logic [size-1:0] branch_target,
    output logic            halted,
    output logic            fault
);

    // Elaboration-time sanity checks on the configuration
    if (IW - 4 > size) begin : g_bad_iw
        $error("pc_fetch_ctrl: JMP immediate (IW-4 bits) wider than size");
    end
    if (TIMEOUT < 1) begin : g_bad_to
        $error("pc_fetch_ctrl: TIMEOUT must be at least 1");
    end

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_UPDATE = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;
    localparam logic [2:0] S_FAULT  = 3'd6;

    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hF;

    logic [2:0]      r_state;
    logic [IW-1:0]   r_ir;
    logic [size-1:0] r_pc_in;
    logic            r_sel;        // 1: load_pc, 0: incr_pc in UPDATE

    logic [3:0]      w_op;
    logic [size-1:0] w_jmp_tgt;
    logic            w_fetch_to;   // watchdog expiry in this FETCH cycle

    assign w_op = r_ir[IW-1:IW-4];

    // Zero-extend the JMP immediate. Building it bit-wise keeps the code
    // legal when IW-4 == size, where the pad would have no bits.
    always_comb begin
        w_jmp_tgt            = '0;
        w_jmp_tgt[IW-5:0]    = r_ir[IW-5:0];
    end

`ifdef FETCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] r_to_cnt;

    // r_to_cnt holds the number of wait cycles already spent in this FETCH.
    // When the current cycle is the TIMEOUT-th wait, the state goes to FAULT.
    // An ack in that cycle takes priority in the state logic.
    assign w_fetch_to = (r_state == S_FETCH) && !mem_ack &&
                        (r_to_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_to_cnt <= '0;
        end else if (((r_state == S_IDLE) || (r_state == S_UPDATE)) && run) begin
            r_to_cnt <= '0;
        end else if ((r_state == S_FETCH) && !mem_ack && !w_fetch_to) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign fault = (r_state == S_FAULT);
`else
    assign w_fetch_to = 1'b0;
    assign fault      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_ir    <= '0;
            r_pc_in <= '0;
            r_sel   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (run) r_state <= S_FETCH;
                end
                S_FETCH: begin
                    if (mem_ack) begin
                        r_ir    <= mem_rdata;
                        r_state <= S_DECODE;
                    end else if (w_fetch_to) begin
                        r_state <= S_FAULT;
                    end
                end
                S_DECODE: begin
                    if (w_op == OP_HALT) begin
                        r_state <= S_HALT;
                    end else if (w_op == OP_JMP) begin
                        r_pc_in <= w_jmp_tgt;
                        r_sel   <= 1'b1;
                        r_state <= S_UPDATE;
                    end else begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // branch_taken/branch_target are sampled only with exec_done
                    if (exec_done) begin
                        if (branch_taken) begin
                            r_pc_in <= branch_target;
                            r_sel   <= 1'b1;
                        end else begin
                            r_sel   <= 1'b0;
                        end
                        r_state <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    r_state <= run ? S_FETCH : S_IDLE;
                end
                S_HALT:  r_state <= S_HALT;
                S_FAULT: r_state <= S_FAULT;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // All outputs are decoded from state and registers. mem_addr forwards pc,
    // which is itself the program_counter register. Forwarding it lets the
    // fetch after UPDATE use the freshly updated PC with no bubble.
    assign mem_req     = (r_state == S_FETCH);
    assign mem_addr    = mem_req ? pc : '0;
    assign instr_valid = (r_state == S_EXEC);
    assign instr       = instr_valid ? r_ir : '0;
    assign load_pc     = (r_state == S_UPDATE) &&  r_sel;
    assign incr_pc     = (r_state == S_UPDATE) && !r_sel;
    assign pc_in       = r_pc_in;
    assign halted      = (r_state == S_HALT);

endmodule
